rf_wb_arbiter: RTL

Write-back controller that owns the single write port of the 32x32 register file.
- After reset it sequences a zero-initialisation sweep of x1..x31.
- It then arbitrates that port between the ALU result path and the load/store unit (LSU) using valid/ready handshakes.
- It keeps a per-register pending-load scoreboard and uses it to stall ALU write-after-write hazards and report read hazards to the issue stage.

---
 rtl/rf_wb_arbiter_pkg.sv | 14 +
 rtl/rf_wb_arbiter_if.sv | 52 +++++
 rtl/rf_wb_arbiter_scoreboard.sv | 71 +++++++
 rtl/rf_wb_arbiter.sv | 119 +++++++++++
 4 files changed

// File: rtl/rf_wb_arbiter_pkg.sv
// Shared constants and types for the register-file write-back controller.
package rf_wb_arbiter_pkg;

  localparam int unsigned XLEN           = 32;
  localparam int unsigned NREG           = 32;
  localparam int unsigned AW             = 5;
  localparam int unsigned STARVE_MAX_DEF = 4;

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

endpackage

// File: rtl/rf_wb_arbiter_if.sv
// Bus bundle between the write-back controller and its clients (ALU, LSU, issue stage).
interface rf_wb_arbiter_if;
  import rf_wb_arbiter_pkg::*;

  logic            alu_valid;
  logic [AW-1:0]   alu_rd;
  logic [XLEN-1:0] alu_data;
  logic            alu_ready;

  logic            lsu_valid;
  logic [AW-1:0]   lsu_rd;
  logic [XLEN-1:0] lsu_data;
  logic            lsu_ready;

  logic            lsu_issue;
  logic [AW-1:0]   lsu_issue_rd;

  logic [AW-1:0]   q_rs1;
  logic [AW-1:0]   q_rs2;
  logic            rs1_pend;
  logic            rs2_pend;

  logic [AW-1:0]   rf_rd;
  logic [XLEN-1:0] rf_wdata;
  logic            init_done;
  logic            sb_err;

  // Controller side
  modport slave (
    input  alu_valid, alu_rd, alu_data,
    output alu_ready,
    input  lsu_valid, lsu_rd, lsu_data,
    output lsu_ready,
    input  lsu_issue, lsu_issue_rd,
    input  q_rs1, q_rs2,
    output rs1_pend, rs2_pend,
    output rf_rd, rf_wdata, init_done, sb_err
  );

  // Client side
  modport master (
    output alu_valid, alu_rd, alu_data,
    input  alu_ready,
    output lsu_valid, lsu_rd, lsu_data,
    input  lsu_ready,
    output lsu_issue, lsu_issue_rd,
    output q_rs1, q_rs2,
    input  rs1_pend, rs2_pend,
    input  rf_rd, rf_wdata, init_done, sb_err
  );

endinterface

// File: rtl/rf_wb_arbiter_scoreboard.sv
// Pending-load scoreboard: one bit per register, set on load issue, cleared on
// load write-back, with a sticky error flag for protocol violations.
module rf_scoreboard
  import rf_wb_arbiter_pkg::*;
(
  input  logic            clk,
  input  logic            reset,
  input  logic            run,
  input  logic            set_en,
  input  logic [AW-1:0]   set_idx,
  input  logic            clr_en,
  input  logic [AW-1:0]   clr_idx,
  input  logic [AW-1:0]   q1_idx,
  input  logic [AW-1:0]   q2_idx,
  output logic            q1_pend,
  output logic            q2_pend,
  output logic [NREG-1:0] pend,
  output logic            sb_err
);

  logic [NREG-1:0] pend_q, pend_d;
  logic            err_q, err_d;
  logic            same_idx;

  // Pending-bit and error next state; set is applied after clear so it wins
  always_comb begin
    pend_d   = pend_q;
    err_d    = err_q;
    same_idx = set_en && clr_en && (set_idx == clr_idx);
    if (!run) begin
      if (set_en) begin
        err_d = 1'b1;
      end
    end else begin
      if (clr_en) begin
        if ((clr_idx != '0) && !pend_q[clr_idx]) begin
          err_d = 1'b1;
        end
        pend_d[clr_idx] = 1'b0;
      end
      if (set_en && (set_idx != '0)) begin
        // Re-issue in the same cycle as the matching write-back is a legal hand-over
        if (pend_q[set_idx] && !same_idx) begin
          err_d = 1'b1;
        end
        pend_d[set_idx] = 1'b1;
      end
      pend_d[0] = 1'b0;
    end
  end

  // Scoreboard state register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pend_q <= '0;
      err_q  <= 1'b0;
    end else begin
      pend_q <= pend_d;
      err_q  <= err_d;
    end
  end

  // Query ports read registered state only
  always_comb begin
    q1_pend = pend_q[q1_idx];
    q2_pend = pend_q[q2_idx];
    pend    = pend_q;
    sb_err  = err_q;
  end

endmodule

// File: rtl/rf_wb_arbiter.sv
// Register-file write-port owner: zero-init sweep after reset, then ALU/LSU
// arbitration with LSU priority, ALU anti-starvation and load WAW stalls.
module rf_wb_arbiter
  import rf_wb_arbiter_pkg::*;
#(
  parameter int unsigned STARVE_MAX = STARVE_MAX_DEF
) (
  input  logic           clk,
  input  logic           reset,
  rf_wb_arbiter_if.slave bus
);

  localparam int unsigned SW = $clog2(STARVE_MAX + 1);

  state_e          state_q, state_d;
  logic [AW-1:0]   init_cnt_q, init_cnt_d;
  logic [SW-1:0]   starve_q, starve_d;

  logic [NREG-1:0] pend;
  logic            run;
  logic            starve_full;
  logic            alu_elig;
  logic            alu_rdy_raw;
  logic            lsu_rdy_raw;
  logic            alu_gnt;
  logic            lsu_gnt;

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_INIT;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state: leave INIT once the last register has been written
  always_comb begin
    state_d = state_q;
    if ((state_q == ST_INIT) && (init_cnt_q == AW'(NREG - 1))) begin
      state_d = ST_RUN;
    end
  end

  // Arbitration; readys are formed without the requester's own valid
  always_comb begin
    run         = (state_q == ST_RUN);
    starve_full = (starve_q == SW'(STARVE_MAX));
    alu_elig    = bus.alu_valid && !pend[bus.alu_rd];
    alu_rdy_raw = !pend[bus.alu_rd] && (!bus.lsu_valid || starve_full);
    lsu_rdy_raw = !(alu_elig && starve_full);
    alu_gnt     = run && bus.alu_valid && alu_rdy_raw;
    lsu_gnt     = run && bus.lsu_valid && lsu_rdy_raw;
  end

  // Init sweep counter and ALU starvation counter next state
  always_comb begin
    init_cnt_d = init_cnt_q;
    starve_d   = '0;
    if (state_q == ST_INIT) begin
      init_cnt_d = init_cnt_q + AW'(1);
    end else if (alu_elig && !alu_gnt) begin
      starve_d = starve_full ? starve_q : starve_q + SW'(1);
    end
  end

  // Counter registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      init_cnt_q <= AW'(1);
      starve_q   <= '0;
    end else begin
      init_cnt_q <= init_cnt_d;
      starve_q   <= starve_d;
    end
  end

  rf_scoreboard u_sb (
    .clk     (clk),
    .reset   (reset),
    .run     (run),
    .set_en  (bus.lsu_issue),
    .set_idx (bus.lsu_issue_rd),
    .clr_en  (lsu_gnt),
    .clr_idx (bus.lsu_rd),
    .q1_idx  (bus.q_rs1),
    .q2_idx  (bus.q_rs2),
    .q1_pend (bus.rs1_pend),
    .q2_pend (bus.rs2_pend),
    .pend    (pend),
    .sb_err  (bus.sb_err)
  );

  // Outputs; reset is folded in so the write port is idle while it is held low
  always_comb begin
    bus.alu_ready = 1'b0;
    bus.lsu_ready = 1'b0;
    bus.init_done = 1'b0;
    bus.rf_rd     = '0;
    bus.rf_wdata  = '0;
    if (reset) begin
      if (state_q == ST_INIT) begin
        bus.rf_rd = init_cnt_q;
      end else begin
        bus.init_done = 1'b1;
        bus.alu_ready = alu_rdy_raw;
        bus.lsu_ready = lsu_rdy_raw;
        if (alu_gnt) begin
          bus.rf_rd    = bus.alu_rd;
          bus.rf_wdata = bus.alu_data;
        end else if (lsu_gnt) begin
          bus.rf_rd    = bus.lsu_rd;
          bus.rf_wdata = bus.lsu_data;
        end
      end
    end
  end

endmodule
